// File: rtl/blink_speed_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared types and constants for the blinker speed controller: the speed index
// type and its limits, the button FSM state encoding, and a saturating step
// helper so the speed target can never wrap around.
// -----------------------------------------------------------------------------
package blink_pkg;

  localparam int SPEED_W   = 4;
  localparam int SPEED_MAX = 15;
  localparam int SPEED_MIN = 0;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT, LOCKOUT} spd_state_e;

  // One step up or down, clamped at the ends of the speed range.
  function automatic speed_t sat_step(input speed_t cur, input logic up);
    speed_t res;
    res = cur;
    if (up) begin
      if (cur != speed_t'(SPEED_MAX)) res = cur + speed_t'(1);
    end else begin
      if (cur != speed_t'(SPEED_MIN)) res = cur - speed_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/blink_speed_ctrl_if.sv
// -----------------------------------------------------------------------------
// blink_speed_ctrl_if
// Valid/ready configuration channel from the speed controller to the blinker.
//   cfg_valid : a new speed index is offered (driven by master)
//   cfg_index : offered speed index, 0 fastest .. 15 slowest (driven by master)
//   cfg_ready : blinker accepts cfg_index this cycle (driven by slave)
// -----------------------------------------------------------------------------
interface blink_speed_ctrl_if;
  import blink_pkg::*;

  logic   cfg_valid;
  logic   cfg_ready;
  speed_t cfg_index;

  modport master (output cfg_valid, output cfg_index, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_index, output cfg_ready);

endinterface

// File: rtl/blink_speed_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push button: 2-flop synchronizer, stability debouncer,
// one-cycle press pulse on a debounced rising edge, and the debounced level.
//   clk, rst : system clock, asynchronous active-high reset
//   btn_i    : raw button, asynchronous to clk
//   press_o  : 1-cycle pulse when the debounced level rises
//   held_o   : debounced button level
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o,
  output logic held_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The reload looks one flop ahead (sync1 vs sync2), so the counter restarts
  // in the same cycle sync2 changes; cnt_q == CNT_DONE therefore always means
  // sync2 has been stable for the full debounce window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_DONE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_q == CNT_DONE) begin
      level_d = sync2_q;
    end
  end

  // Synchronizer, debounce counter and registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign press_o = press_q;
  assign held_o  = level_q;

endmodule

// File: rtl/blink_speed_ctrl.sv
// -----------------------------------------------------------------------------
// blink_speed_ctrl
// Turns the up/down buttons into a saturating 0..15 speed target with
// hold-to-auto-repeat, and hands each new index to the blinker over a
// valid/ready channel.
//   clk, rst      : 100 MHz clock, asynchronous active-high reset
//   btnu_i/btnd_i : raw up/down buttons
//   cfg           : valid/ready channel to the blinker (master side)
//   speed_index_o : last index accepted by the blinker
//   pending_o     : target differs from speed_index_o, or an offer is open
// -----------------------------------------------------------------------------
module blink_speed_ctrl
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000,
  parameter int RESET_INDEX     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btnu_i,
  input  logic                       btnd_i,
  blink_speed_ctrl_if.master         cfg,
  output speed_t                     speed_index_o,
  output logic                       pending_o
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  localparam speed_t RST_IDX = speed_t'(RESET_INDEX);

  logic up_press, up_held, dn_press, dn_held;
  logic both_held, active_held, step_up, step_dn;

  spd_state_e       state_q;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic             dir_up_q;
  speed_t           target_q, target_d;

  logic   valid_q, valid_d;
  speed_t cfg_index_q, cfg_index_d;
  speed_t speed_q, speed_d;
  logic   pending_q, pending_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_i(btnu_i), .press_o(up_press), .held_o(up_held)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk(clk), .rst(rst), .btn_i(btnd_i), .press_o(dn_press), .held_o(dn_held)
  );

  assign both_held   = up_held & dn_held;
  assign active_held = dir_up_q ? up_held : dn_held;

  // Step decode. Both buttons held (which includes both pressed in the same
  // cycle) suppresses every step; repeat steps fire on the last count.
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    if (!both_held) begin
      case (state_q)
        IDLE: begin
          if (up_press && !dn_held)      step_up = 1'b1;
          else if (dn_press && !up_held) step_dn = 1'b1;
        end
        HOLD_WAIT: begin
          if (active_held && rpt_cnt_q == DELAY_LAST) begin
            step_up = dir_up_q;
            step_dn = ~dir_up_q;
          end
        end
        REPEAT: begin
          if (active_held && rpt_cnt_q == RATE_LAST) begin
            step_up = dir_up_q;
            step_dn = ~dir_up_q;
          end
        end
        default: ;
      endcase
    end
    target_d = target_q;
    if (step_up)      target_d = sat_step(target_q, 1'b1);
    else if (step_dn) target_d = sat_step(target_q, 1'b0);
  end

  // Button FSM, repeat counter and speed target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      dir_up_q  <= 1'b0;
      target_q  <= RST_IDX;
    end else begin
      target_q <= target_d;
      if (both_held) begin
        state_q   <= LOCKOUT;
        rpt_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (step_up || step_dn) begin
              state_q   <= HOLD_WAIT;
              rpt_cnt_q <= '0;
              dir_up_q  <= step_up;
            end
          end
          HOLD_WAIT: begin
            if (!active_held) begin
              state_q   <= IDLE;
              rpt_cnt_q <= '0;
            end else if (rpt_cnt_q == DELAY_LAST) begin
              state_q   <= REPEAT;
              rpt_cnt_q <= '0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
            end
          end
          REPEAT: begin
            if (!active_held) begin
              state_q   <= IDLE;
              rpt_cnt_q <= '0;
            end else if (rpt_cnt_q == RATE_LAST) begin
              rpt_cnt_q <= '0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
            end
          end
          LOCKOUT: begin
            if (!up_held && !dn_held) begin
              state_q   <= IDLE;
              rpt_cnt_q <= '0;
            end
          end
          default: begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  // Handshake: an offer snapshots the target and stays frozen until accepted;
  // after acceptance valid spends at least one cycle low before re-offering.
  always_comb begin
    valid_d     = valid_q;
    cfg_index_d = cfg_index_q;
    speed_d     = speed_q;
    if (valid_q) begin
      if (cfg.cfg_ready) begin
        valid_d = 1'b0;
        speed_d = cfg_index_q;
      end
    end else if (target_q != speed_q) begin
      valid_d     = 1'b1;
      cfg_index_d = target_q;
    end
    pending_d = (target_d != speed_d) || valid_d;
  end

  // Handshake registers; pending is registered from the next-state values so
  // it matches the current target/speed/valid registers exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      cfg_index_q <= RST_IDX;
      speed_q     <= RST_IDX;
      pending_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      cfg_index_q <= cfg_index_d;
      speed_q     <= speed_d;
      pending_q   <= pending_d;
    end
  end

  assign cfg.cfg_valid  = valid_q;
  assign cfg.cfg_index  = cfg_index_q;
  assign speed_index_o  = speed_q;
  assign pending_o      = pending_q;

endmodule

// File: tb/tb_blink_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_blink_speed_ctrl
// Scoreboard bench for blink_speed_ctrl. Button presses update a plain integer
// model of the speed target and queue the indices the blinker should accept;
// a monitor pops and compares on every accepted transfer.
// -----------------------------------------------------------------------------
module tb_blink_speed_ctrl;
  import blink_pkg::*;

  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int RATE = 5;
  localparam int RIDX = 3;

  logic   clk = 1'b0;
  logic   rst;
  logic   btnu, btnd;
  speed_t speed_index;
  logic   pending;

  blink_speed_ctrl_if cfg_if();

  blink_speed_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .RESET_INDEX(RIDX)
  ) dut (
    .clk(clk), .rst(rst), .btnu_i(btnu), .btnd_i(btnd), .cfg(cfg_if),
    .speed_index_o(speed_index), .pending_o(pending)
  );

  always #5 clk = ~clk;

  int checks;
  int fails;
  int modelTgt;
  int expq[$];
  bit satMode;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int satMove(input int cur, input bit up);
    if (up) return (cur >= 15) ? 15 : cur + 1;
    return (cur <= 0) ? 0 : cur - 1;
  endfunction

  // Steps produced by holding a button for 'hold' cycles: one at the press,
  // one at DLY, then one every RATE while still held.
  function automatic int stepsForHold(input int hold);
    int n;
    n = 1;
    for (int t = DLY; t < hold; t += RATE) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic applyStimulus(input bit up, input int hold, input bit pushEach);
    int n;
    int nxt;
    n = stepsForHold(hold);
    for (int i = 0; i < n; i++) begin
      nxt = satMove(modelTgt, up);
      if (pushEach && nxt != modelTgt) expq.push_back(nxt);
      modelTgt = nxt;
    end
    @(posedge clk); #1;
    if (up) btnu = 1'b1; else btnd = 1'b1;
    waitCycles(hold); #1;
    if (up) btnu = 1'b0; else btnd = 1'b0;
    waitCycles(15);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst  = 1'b1;
    btnu = 1'b0;
    btnd = 1'b0;
    waitCycles(3); #1;
    rst = 1'b0;
    modelTgt = RIDX;
    expq.delete();
  endtask

  task automatic endScenario(input string tag);
    waitCycles(10);
    @(negedge clk);
    checkOutput({tag, "_speed"}, int'(speed_index), modelTgt);
    checkOutput({tag, "_pending"}, int'(pending), 0);
    checkOutput({tag, "_drained"}, expq.size(), 0);
  endtask

  // Monitor: compares every accepted index against the scoreboard and checks
  // the channel rules (frozen offer while stalled, low cycle after acceptance).
  task automatic monitorLoop();
    bit     pv, pr, pa;
    speed_t pi;
    pv = 0; pr = 0; pa = 0; pi = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; pr = 0; pa = 0;
        continue;
      end
      if (pv && !pr) begin
        checkOutput("stall_valid_held", int'(cfg_if.cfg_valid), 1);
        checkOutput("stall_index_held", int'(cfg_if.cfg_index), int'(pi));
      end
      if (pa) checkOutput("low_after_accept", int'(cfg_if.cfg_valid), 0);
      if (cfg_if.cfg_valid && cfg_if.cfg_ready) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_accept: actual=%0d required=no offer",
                   cfg_if.cfg_index);
        end else begin
          checkOutput("accept_index", int'(cfg_if.cfg_index), expq.pop_front());
        end
      end
      if (satMode && cfg_if.cfg_valid)
        checkOutput("offer_not_above_3", int'(cfg_if.cfg_index <= 4'd3), 1);
      pv = cfg_if.cfg_valid;
      pr = cfg_if.cfg_ready;
      pi = cfg_if.cfg_index;
      pa = cfg_if.cfg_valid && cfg_if.cfg_ready;
    end
  endtask

  initial begin
    int first;
    int budget;
    int m;
    int hold;
    bit up;
    checks = 0;
    fails  = 0;
    satMode = 0;
    modelTgt = RIDX;
    rst  = 1'b1;
    btnu = 1'b0;
    btnd = 1'b0;
    cfg_if.cfg_ready = 1'b1;
    fork
      monitorLoop();
    join_none

    // Reset state
    waitCycles(3);
    @(negedge clk);
    checkOutput("rst_speed_index", int'(speed_index), RIDX);
    checkOutput("rst_cfg_index", int'(cfg_if.cfg_index), RIDX);
    checkOutput("rst_cfg_valid", int'(cfg_if.cfg_valid), 0);
    checkOutput("rst_pending", int'(pending), 0);
    checkOutput("rst_state", int'(dut.state_q), int'(IDLE));
    #2 rst = 1'b0;

    // Bounce: 2-cycle glitches must be ignored, then a clean 10-cycle press
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      btnu = (i % 2 == 0);
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("bounce_no_step", int'(pending), 0);
    applyStimulus(1'b1, 10, 1'b1);
    endScenario("bounce");
    checkOutput("bounce_cfg_index", int'(cfg_if.cfg_index), 4);

    // Auto-repeat: press, +20, +25, +30 -> 7
    doReset();
    applyStimulus(1'b1, 32, 1'b1);
    endScenario("repeat");
    waitCycles(30);
    @(negedge clk);
    checkOutput("repeat_no_step_after_release", int'(speed_index), 7);

    // Saturation at the bottom
    doReset();
    satMode = 1;
    applyStimulus(1'b0, 200, 1'b1);
    endScenario("sat");
    satMode = 0;

    // Stalled handshake: offer frozen at 4, then 6 after the gap
    doReset();
    @(posedge clk); #1;
    cfg_if.cfg_ready = 1'b0;
    first = satMove(modelTgt, 1'b1);
    expq.push_back(first);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 10, 1'b0);
    @(negedge clk);
    checkOutput("stall_valid", int'(cfg_if.cfg_valid), 1);
    checkOutput("stall_index", int'(cfg_if.cfg_index), 4);
    checkOutput("stall_speed", int'(speed_index), 3);
    checkOutput("stall_pending", int'(pending), 1);
    if (modelTgt != first) expq.push_back(modelTgt);
    @(posedge clk); #1;
    cfg_if.cfg_ready = 1'b1;
    endScenario("stall");

    // Simultaneous press -> lockout, then a single clean press
    doReset();
    @(posedge clk); #1;
    btnu = 1'b1;
    btnd = 1'b1;
    waitCycles(20);
    @(negedge clk);
    checkOutput("lock_state", int'(dut.state_q), int'(LOCKOUT));
    checkOutput("lock_no_step", int'(pending), 0);
    waitCycles(20); #1;
    btnu = 1'b0;
    btnd = 1'b0;
    waitCycles(15);
    @(negedge clk);
    checkOutput("lock_exit_idle", int'(dut.state_q), int'(IDLE));
    applyStimulus(1'b1, 10, 1'b1);
    endScenario("lock");

    // Randomized presses: direction and hold length chosen clear of the
    // repeat-step boundaries
    doReset();
    for (int r = 0; r < 10; r++) begin
      up = 1'($urandom_range(0, 1));
      m  = int'($urandom_range(0, 3));
      hold = (m == 0) ? int'($urandom_range(8, 14)) : 22 + 5 * (m - 1);
      applyStimulus(up, hold, 1'b1);
    end
    endScenario("random");

    // Reset mid-operation while an offer is open in REPEAT
    doReset();
    @(posedge clk); #1;
    cfg_if.cfg_ready = 1'b0;
    btnu = 1'b1;
    budget = 0;
    while (!(dut.state_q == REPEAT && cfg_if.cfg_valid) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("reach_repeat_in_budget", int'(budget < 200), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_cfg_valid", int'(cfg_if.cfg_valid), 0);
    checkOutput("midrst_speed_index", int'(speed_index), 3);
    checkOutput("midrst_cfg_index", int'(cfg_if.cfg_index), 3);
    checkOutput("midrst_pending", int'(pending), 0);
    checkOutput("midrst_state", int'(dut.state_q), int'(IDLE));
    btnu = 1'b0;
    cfg_if.cfg_ready = 1'b1;
    waitCycles(2); #1;
    rst = 1'b0;
    modelTgt = RIDX;
    expq.delete();
    endScenario("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
